// File: rtl/stage_buf_pkg.sv
// Shared constants and helpers for the stage_buf pipeline buffer.
package stage_buf_pkg;

    localparam int unsigned PERF_W = 32;

    // A single-entry buffer still needs a one-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stage_buf_sat_counter.sv
// Saturating up-counter with synchronous clear, used for performance statistics.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk) begin
        if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/stage_buf.sv
// Registered-handshake FIFO stage with flush; STAGE_BUF_PERF_EN adds stall/bubble counters.
module stage_buf
    import stage_buf_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       i_valid,
    output logic                       i_ready,
    input  logic [DATA_W-1:0]          i_data,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [DATA_W-1:0]          o_data,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef STAGE_BUF_PERF_EN
    ,
    output logic [PERF_W-1:0]          stall_cnt,
    output logic [PERF_W-1:0]          bubble_cnt
`endif
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_c;
    logic              pop_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake outputs come only from registered occupancy and storage.
    assign i_ready = (count != FULL);
    assign o_valid = (count != '0);
    assign o_data  = mem[rd_ptr];

    assign push_c = i_valid && i_ready && !flush;
    assign pop_c  = o_valid && o_ready && !flush;

    // Entry 0 is cleared on reset since it drives o_data once pointers return to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mem[0] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef STAGE_BUF_PERF_EN
    // Statistics survive flush; only reset clears them.
    sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (i_valid && !i_ready),
        .value (stall_cnt)
    );

    sat_counter #(.WIDTH(PERF_W)) u_bubble_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (o_ready && !o_valid),
        .value (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_stage_buf.sv
// Self-checking bench for stage_buf: three instances (DEPTH 2, 3, 1) against a queue model.
module tb_stage_buf;

    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          fl   [3];
    logic          iv   [3];
    logic          ordy [3];
    logic [DW-1:0] id   [3];
    logic          ir   [3];
    logic          ov   [3];
    logic [DW-1:0] od   [3];
    logic [1:0]    cnt0;
    logic [1:0]    cnt1;
    logic [0:0]    cnt2;
`ifdef STAGE_BUF_PERF_EN
    logic [31:0]   stall  [3];
    logic [31:0]   bubble [3];
`endif

    int checks = 0;
    int errors = 0;
    int mdepth [3] = '{2, 3, 1};
    logic [DW-1:0] q [$];
    int stall_m;
    int bubble_m;

    always #5 clk = ~clk;

    stage_buf #(.DATA_W(DW), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .flush(fl[0]), .i_valid(iv[0]), .i_ready(ir[0]),
        .i_data(id[0]), .o_valid(ov[0]), .o_ready(ordy[0]), .o_data(od[0]), .count(cnt0)
`ifdef STAGE_BUF_PERF_EN
        , .stall_cnt(stall[0]), .bubble_cnt(bubble[0])
`endif
    );

    stage_buf #(.DATA_W(DW), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .flush(fl[1]), .i_valid(iv[1]), .i_ready(ir[1]),
        .i_data(id[1]), .o_valid(ov[1]), .o_ready(ordy[1]), .o_data(od[1]), .count(cnt1)
`ifdef STAGE_BUF_PERF_EN
        , .stall_cnt(stall[1]), .bubble_cnt(bubble[1])
`endif
    );

    stage_buf #(.DATA_W(DW), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .flush(fl[2]), .i_valid(iv[2]), .i_ready(ir[2]),
        .i_data(id[2]), .o_valid(ov[2]), .o_ready(ordy[2]), .o_data(od[2]), .count(cnt2)
`ifdef STAGE_BUF_PERF_EN
        , .stall_cnt(stall[2]), .bubble_cnt(bubble[2])
`endif
    );

    function automatic int get_cnt(input int k);
        case (k)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    // Drive one cycle on instance k, advance the model at the edge, return at the falling edge.
    task automatic cycle(input int k, input logic v, input logic [DW-1:0] d,
                         input logic r, input logic f);
        bit do_pop;
        bit do_push;
        iv[k] = v; id[k] = d; ordy[k] = r; fl[k] = f;
        @(posedge clk);
        if (v && (q.size() == mdepth[k])) stall_m++;
        if (r && (q.size() == 0)) bubble_m++;
        if (f) begin
            q.delete();
        end else begin
            do_pop  = (q.size() != 0) && r;
            do_push = v && (q.size() < mdepth[k]);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; fl[k] = 1'b0; id[k] = '0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        stall_m = 0;
        bubble_m = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        // Load nonzero data into every instance so a cleared head entry is observable.
        for (int k = 0; k < 3; k++) begin
            cycle(k, 1'b1, {$urandom, $urandom} | 64'h1, 1'b0, 1'b0);
            iv[k] = 1'b0;
        end
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (get_cnt(k) !== 0) begin
                errors++; $display("FAIL reset_count k=%0d got %0d exp 0", k, get_cnt(k));
            end
            checks++;
            if (ov[k] !== 1'b0) begin
                errors++; $display("FAIL reset_o_valid k=%0d got %b exp 0", k, ov[k]);
            end
            checks++;
            if (ir[k] !== 1'b1) begin
                errors++; $display("FAIL reset_i_ready k=%0d got %b exp 1", k, ir[k]);
            end
            checks++;
            if (od[k] !== '0) begin
                errors++; $display("FAIL reset_o_data k=%0d got %0h exp 0", k, od[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        cycle(0, 1'b1, 64'hA, 1'b0, 1'b0);
        cycle(0, 1'b1, 64'hB, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (cnt0 !== 2'd2) begin
                errors++; $display("FAIL b2b_count got %0d exp 2", cnt0);
            end
            checks++;
            if (ir[0] !== 1'b0) begin
                errors++; $display("FAIL b2b_i_ready got %b exp 0", ir[0]);
            end
            checks++;
            if (ov[0] !== 1'b1 || od[0] !== 64'hA) begin
                errors++; $display("FAIL b2b_head got v=%b d=%0h exp v=1 d=a", ov[0], od[0]);
            end
            cycle(0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        end
        // Full with a same-cycle pop: the push must still be refused.
        cycle(0, 1'b1, 64'hC, 1'b1, 1'b0);
        checks++;
        if (cnt0 !== 2'd1 || od[0] !== 64'hB || ir[0] !== 1'b1) begin
            errors++; $display("FAIL full_pop got cnt=%0d d=%0h rdy=%b exp cnt=1 d=b rdy=1",
                               cnt0, od[0], ir[0]);
        end
        cycle(0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (cnt0 !== 2'd0 || ov[0] !== 1'b0) begin
            errors++; $display("FAIL full_pop_drain got cnt=%0d v=%b exp cnt=0 v=0", cnt0, ov[0]);
        end
        iv[0] = 1'b0; ordy[0] = 1'b0;
    endtask

    task automatic test_stream();
        int exp_next;
        int pops;
        int bubbles;
        bit seen;
        apply_reset();
        exp_next = 0; pops = 0; bubbles = 0; seen = 1'b0;
        for (int c = 0; c < 103; c++) begin
            if (c == 1) begin
                checks++;
                if (ov[0] !== 1'b1 || od[0] !== 64'd0) begin
                    errors++; $display("FAIL stream_latency got v=%b d=%0h exp v=1 d=0", ov[0], od[0]);
                end
            end
            if (ov[0] === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (od[0] !== DW'(exp_next)) begin
                    errors++; $display("FAIL stream_order got %0h exp %0h", od[0], exp_next);
                end
                exp_next++;
                pops++;
            end else if (seen && pops < 100) begin
                bubbles++;
            end
            cycle(0, c < 100, DW'(c), 1'b1, 1'b0);
        end
        checks++;
        if (pops !== 100) begin
            errors++; $display("FAIL stream_pops got %0d exp 100", pops);
        end
        checks++;
        if (bubbles !== 0) begin
            errors++; $display("FAIL stream_bubbles got %0d exp 0", bubbles);
        end
        iv[0] = 1'b0; ordy[0] = 1'b0;
    endtask

    task automatic test_wrap();
        int c;
        apply_reset();
        c = 0;
        while (c < 60 || (c < 200 && q.size() != 0)) begin
            checks++;
            if (get_cnt(1) !== q.size()) begin
                errors++; $display("FAIL wrap_count cyc=%0d got %0d exp %0d", c, get_cnt(1), q.size());
            end
            checks++;
            if (ov[1] !== (q.size() != 0) || ir[1] !== (q.size() != 3)) begin
                errors++; $display("FAIL wrap_flags cyc=%0d got v=%b r=%b exp size %0d",
                                   c, ov[1], ir[1], q.size());
            end
            if (q.size() != 0) begin
                checks++;
                if (od[1] !== q[0]) begin
                    errors++; $display("FAIL wrap_data cyc=%0d got %0h exp %0h", c, od[1], q[0]);
                end
            end
            if (c < 60) cycle(1, ($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 2) == 1, 1'b0);
            else        cycle(1, 1'b0, '0, 1'b1, 1'b0);
            c++;
        end
        checks++;
        if (q.size() != 0 || ov[1] !== 1'b0) begin
            errors++; $display("FAIL wrap_drain got v=%b exp 0 model %0d", ov[1], q.size());
        end
        iv[1] = 1'b0; ordy[1] = 1'b0;
    endtask

    task automatic test_flush();
        apply_reset();
        cycle(0, 1'b1, 64'h11, 1'b0, 1'b0);
        cycle(0, 1'b1, 64'h22, 1'b0, 1'b0);
        checks++;
        if (cnt0 !== 2'd2 || ir[0] !== 1'b0) begin
            errors++; $display("FAIL flush_full got cnt=%0d rdy=%b exp cnt=2 rdy=0", cnt0, ir[0]);
        end
        cycle(0, 1'b1, 64'hDEAD, 1'b1, 1'b1);
        checks++;
        if (cnt0 !== 2'd0 || ov[0] !== 1'b0) begin
            errors++; $display("FAIL flush_clear got cnt=%0d v=%b exp cnt=0 v=0", cnt0, ov[0]);
        end
        for (int c = 0; c < 3; c++) begin
            cycle(0, 1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (ov[0] !== 1'b0) begin
                errors++; $display("FAIL flush_leak got v=%b d=%0h exp v=0", ov[0], od[0]);
            end
        end
        // Partially full: i_ready stays high through the flush cycle.
        cycle(0, 1'b1, 64'h33, 1'b0, 1'b0);
        checks++;
        if (ir[0] !== 1'b1 || cnt0 !== 2'd1) begin
            errors++; $display("FAIL flush_part got rdy=%b cnt=%0d exp rdy=1 cnt=1", ir[0], cnt0);
        end
        cycle(0, 1'b1, 64'h44, 1'b0, 1'b1);
        checks++;
        if (cnt0 !== 2'd0 || ov[0] !== 1'b0) begin
            errors++; $display("FAIL flush_part_clear got cnt=%0d v=%b exp 0", cnt0, ov[0]);
        end
        // Buffer resumes with pointers at 0 after a flush.
        cycle(0, 1'b1, 64'h55, 1'b0, 1'b0);
        checks++;
        if (ov[0] !== 1'b1 || od[0] !== 64'h55) begin
            errors++; $display("FAIL flush_resume got v=%b d=%0h exp v=1 d=55", ov[0], od[0]);
        end
        iv[0] = 1'b0; fl[0] = 1'b0; ordy[0] = 1'b0;
    endtask

    task automatic test_depth1();
        int pops;
        logic prev;
        apply_reset();
        pops = 0;
        prev = ov[2];
        for (int c = 0; c < 100; c++) begin
            if (c > 0) begin
                checks++;
                if (ov[2] === prev) begin
                    errors++; $display("FAIL d1_toggle cyc=%0d got %b exp %b", c, ov[2], ~prev);
                end
            end
            if (q.size() != 0) begin
                checks++;
                if (od[2] !== q[0]) begin
                    errors++; $display("FAIL d1_data cyc=%0d got %0h exp %0h", c, od[2], q[0]);
                end
            end
            if (ov[2] === 1'b1) pops++;
            prev = ov[2];
            cycle(2, 1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
        end
        checks++;
        if (pops !== 50) begin
            errors++; $display("FAIL d1_pops got %0d exp 50", pops);
        end
        iv[2] = 1'b0; ordy[2] = 1'b0;
    endtask

`ifdef STAGE_BUF_PERF_EN
    task automatic test_perf();
        apply_reset();
        cycle(0, 1'b1, 64'h1, 1'b0, 1'b0);
        cycle(0, 1'b1, 64'h2, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) cycle(0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        iv[0] = 1'b0;
        checks++;
        if (stall[0] !== 32'd5 || stall_m != 5) begin
            errors++; $display("FAIL perf_stall got %0d exp 5 (model %0d)", stall[0], stall_m);
        end
        checks++;
        if (bubble[0] !== 32'd0) begin
            errors++; $display("FAIL perf_bubble_idle got %0d exp 0", bubble[0]);
        end
        cycle(0, 1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (stall[0] !== 32'd5) begin
            errors++; $display("FAIL perf_flush_keep got %0d exp 5", stall[0]);
        end
        for (int c = 0; c < 3; c++) cycle(0, 1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (bubble[0] !== 32'(bubble_m) || bubble_m != 3) begin
            errors++; $display("FAIL perf_bubble got %0d exp 3 (model %0d)", bubble[0], bubble_m);
        end
        apply_reset();
        checks++;
        if (stall[0] !== 32'd0 || bubble[0] !== 32'd0) begin
            errors++; $display("FAIL perf_reset got stall=%0d bubble=%0d exp 0 0", stall[0], bubble[0]);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; fl[k] = 1'b0; id[k] = '0;
        end
        test_reset();
        test_back_to_back();
        test_stream();
        test_wrap();
        test_flush();
        test_depth1();
`ifdef STAGE_BUF_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
